mem_arbiter: RTL and testbench

//   Shares one single-ported backing memory bus between the fetch port (read-only, word) and the mem-stage port (R/W, byte/half/word).

---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one backing memory bus between fetch (read-only) and the mem stage (priority, with starvation guard).
// Optional bus timeout abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fe_req,
    input  logic [31:0] fe_addr,
    output logic        fe_ack,
    output logic [31:0] fe_data,
    output logic        fe_err,
    input  logic        mem_req,
    input  logic [31:0] mem_addr,
    input  logic        mem_write,
    input  logic [31:0] mem_wdata,
    input  logic        mem_extend,
    input  logic [1:0]  mem_width,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic        bus_write,
    output logic [31:0] bus_wdata,
    output logic        bus_extend,
    output logic [1:0]  bus_width,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    if (STARVE_LIMIT < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_arbiter: STARVE_LIMIT and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t        state;
    logic          grant_mem;
    logic [SW-1:0] starve_cnt;
    logic          mem_wins;

    // Mem stage wins unless fetch is waiting and has already been passed over STARVE_LIMIT times.
    assign mem_wins = mem_req && (!fe_req || (starve_cnt < STARVE_MAX));

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt;
`else
    assign fe_err  = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant_mem  <= 1'b0;
            starve_cnt <= '0;
            fe_ack     <= 1'b0;
            fe_data    <= '0;
            mem_ack    <= 1'b0;
            mem_rdata  <= '0;
            bus_req    <= 1'b0;
            bus_addr   <= '0;
            bus_write  <= 1'b0;
            bus_wdata  <= '0;
            bus_extend <= 1'b0;
            bus_width  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            fe_err     <= 1'b0;
            mem_err    <= 1'b0;
            tcnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (mem_wins) begin
                        grant_mem  <= 1'b1;
                        bus_req    <= 1'b1;
                        bus_addr   <= mem_addr;
                        bus_write  <= mem_write;
                        bus_wdata  <= mem_wdata;
                        bus_extend <= mem_extend;
                        bus_width  <= mem_width;
                        state      <= BUS;
                        if (!fe_req)
                            starve_cnt <= '0;
                        else if (starve_cnt != STARVE_MAX)
                            starve_cnt <= starve_cnt + SW'(1);
`ifdef MEM_ARB_TIMEOUT_EN
                        tcnt       <= '0;
`endif
                    end else if (fe_req) begin
                        grant_mem  <= 1'b0;
                        bus_req    <= 1'b1;
                        bus_addr   <= fe_addr;
                        bus_write  <= 1'b0;
                        bus_wdata  <= '0;
                        bus_extend <= 1'b0;
                        bus_width  <= 2'b10;
                        state      <= BUS;
                        starve_cnt <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
                        tcnt       <= '0;
`endif
                    end
                end
                BUS: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= RESP;
                        if (grant_mem) begin
                            mem_ack   <= 1'b1;
                            mem_rdata <= bus_rdata;
                        end else begin
                            fe_ack  <= 1'b1;
                            fe_data <= bus_rdata;
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                    end else if (tcnt == TIMEOUT_LAST) begin
                        // Abort: ack with error and zero data; bus_req held exactly TIMEOUT_CYCLES cycles.
                        bus_req <= 1'b0;
                        state   <= RESP;
                        if (grant_mem) begin
                            mem_ack <= 1'b1;
                            mem_err <= 1'b1;
                        end else begin
                            fe_ack <= 1'b1;
                            fe_err <= 1'b1;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
`endif
                    end
                end
                RESP: begin
                    fe_ack    <= 1'b0;
                    fe_data   <= '0;
                    mem_ack   <= 1'b0;
                    mem_rdata <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    fe_err    <= 1'b0;
                    mem_err   <= 1'b0;
`endif
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus hand-written arbitration,
// starvation, reset and (with MEM_ARB_TIMEOUT_EN) timeout sequences.
module tb_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        fe_req;
    logic [31:0] fe_addr;
    logic        fe_ack;
    logic [31:0] fe_data;
    logic        fe_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic        mem_extend;
    logic [1:0]  mem_width;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_write;
    logic [31:0] bus_wdata;
    logic        bus_extend;
    logic [1:0]  bus_width;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .fe_req(fe_req), .fe_addr(fe_addr), .fe_ack(fe_ack), .fe_data(fe_data), .fe_err(fe_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_extend(mem_extend), .mem_width(mem_width), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_err(mem_err), .bus_req(bus_req), .bus_addr(bus_addr), .bus_write(bus_write),
        .bus_wdata(bus_wdata), .bus_extend(bus_extend), .bus_width(bus_width),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        fe_req;
        logic [31:0] fe_addr;
        logic        mem_req;
        logic [31:0] mem_addr;
        logic        mem_write;
        logic [31:0] mem_wdata;
        logic        mem_extend;
        logic [1:0]  mem_width;
        int          delay;
        logic [31:0] rdata;
        logic        exp_mem;
        logic [31:0] exp_addr;
        logic        exp_write;
        logic [31:0] exp_wdata;
        logic        exp_extend;
        logic [1:0]  exp_width;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One complete transaction starting from IDLE, requests already driven; returns in the IDLE cycle after RESP.
    task automatic runTxn(input string tag, input logic exp_mem, input logic [31:0] exp_addr,
                          input logic exp_write, input logic [31:0] exp_wdata, input logic exp_extend,
                          input logic [1:0] exp_width, input int delay, input logic [31:0] rdata,
                          input logic drop_fe, input logic drop_mem);
        int n = 0;
        while (!bus_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " grant latency"}, n, 1);
        if (!bus_req) return;
        checkOutput({tag, " bus_addr"}, bus_addr, exp_addr);
        checkOutput({tag, " bus_wdata"}, bus_wdata, exp_wdata);
        checkOutput({tag, " write/extend/width"}, {bus_write, bus_extend, bus_width},
                    {exp_write, exp_extend, exp_width});
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            checkOutput({tag, " bus_req held"}, {bus_req, bus_addr}, {1'b1, exp_addr});
        end
        bus_ack = 1'b1;
        bus_rdata = rdata;
        @(negedge clk);
        bus_ack = 1'b0;
        bus_rdata = 32'h0;
        checkOutput({tag, " bus_req after ack"}, bus_req, 0);
        checkOutput({tag, " acks fe/mem"}, {fe_ack, mem_ack}, {!exp_mem, exp_mem});
        checkOutput({tag, " errs fe/mem"}, {fe_err, mem_err}, 0);
        if (exp_mem) begin
            checkOutput({tag, " mem_rdata"}, mem_rdata, rdata);
            checkOutput({tag, " idle fe_data"}, fe_data, 0);
        end else begin
            checkOutput({tag, " fe_data"}, fe_data, rdata);
            checkOutput({tag, " idle mem_rdata"}, mem_rdata, 0);
        end
        if (drop_fe) fe_req = 1'b0;
        if (drop_mem) mem_req = 1'b0;
        @(negedge clk);
        checkOutput({tag, " ack single pulse"}, {fe_ack, mem_ack}, 0);
    endtask

    task automatic applyStimulus(input int i);
        fe_req     = vecs[i].fe_req;
        fe_addr    = vecs[i].fe_addr;
        mem_req    = vecs[i].mem_req;
        mem_addr   = vecs[i].mem_addr;
        mem_write  = vecs[i].mem_write;
        mem_wdata  = vecs[i].mem_wdata;
        mem_extend = vecs[i].mem_extend;
        mem_width  = vecs[i].mem_width;
        runTxn($sformatf("v%0d", i), vecs[i].exp_mem, vecs[i].exp_addr, vecs[i].exp_write,
               vecs[i].exp_wdata, vecs[i].exp_extend, vecs[i].exp_width, vecs[i].delay,
               vecs[i].rdata, 1'b1, 1'b1);
    endtask

    initial begin
        // fe_req fe_addr mem_req mem_addr write wdata ext width delay rdata | exp_mem addr write wdata ext width
        vecs[0] = '{1'b1, 32'h100, 1'b0, 32'h0,    1'b0, 32'h0,        1'b0, 2'b00, 2, 32'h00000013,
                    1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 2'b10};
        vecs[1] = '{1'b0, 32'h0,   1'b1, 32'h2000, 1'b0, 32'h0,        1'b0, 2'b10, 0, 32'hDEADBEEF,
                    1'b1, 32'h2000, 1'b0, 32'h0, 1'b0, 2'b10};
        vecs[2] = '{1'b0, 32'h0,   1'b1, 32'h203,  1'b1, 32'hAB,       1'b0, 2'b00, 1, 32'h0,
                    1'b1, 32'h203, 1'b1, 32'hAB, 1'b0, 2'b00};
        vecs[3] = '{1'b0, 32'h0,   1'b1, 32'h1002, 1'b0, 32'h0,        1'b1, 2'b01, 3, 32'hFFFF8001,
                    1'b1, 32'h1002, 1'b0, 32'h0, 1'b1, 2'b01};
        vecs[4] = '{1'b1, 32'h104, 1'b0, 32'h0,    1'b1, 32'h55,       1'b1, 2'b00, 1, 32'h00500093,
                    1'b0, 32'h104, 1'b0, 32'h0, 1'b0, 2'b10};
        vecs[5] = '{1'b0, 32'h0,   1'b1, 32'h3000, 1'b1, 32'h12345678, 1'b0, 2'b10, 0, 32'hCAFEF00D,
                    1'b1, 32'h3000, 1'b1, 32'h12345678, 1'b0, 2'b10};

        reset_n = 1'b0;
        fe_req = 1'b0; fe_addr = '0;
        mem_req = 1'b0; mem_addr = '0; mem_write = 1'b0; mem_wdata = '0;
        mem_extend = 1'b0; mem_width = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset bus ctrl", {bus_req, bus_write, bus_extend, bus_width, fe_ack, mem_ack, fe_err, mem_err}, 0);
        checkOutput("reset bus_addr|wdata", bus_addr | bus_wdata, 0);
        checkOutput("reset fe_data|mem_rdata", fe_data | mem_rdata, 0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] table vectors");
        for (int i = 0; i < 6; i++) applyStimulus(i);

        $display("[TB] simultaneous requests: mem first, then fetch");
        fe_req = 1'b1; fe_addr = 32'h300;
        mem_req = 1'b1; mem_addr = 32'h2000; mem_write = 1'b0; mem_wdata = '0;
        mem_extend = 1'b0; mem_width = 2'b10;
        runTxn("both-mem", 1'b1, 32'h2000, 1'b0, 32'h0, 1'b0, 2'b10, 1, 32'h11111111, 1'b0, 1'b1);
        runTxn("both-fe", 1'b0, 32'h300, 1'b0, 32'h0, 1'b0, 2'b10, 1, 32'h22222222, 1'b1, 1'b0);

        $display("[TB] starvation guard");
        fe_req = 1'b1; fe_addr = 32'h500;
        mem_req = 1'b1; mem_addr = 32'h4000; mem_write = 1'b1; mem_wdata = 32'h77;
        mem_extend = 1'b0; mem_width = 2'b10;
        for (int g = 0; g < 4; g++)
            runTxn($sformatf("starve-mem%0d", g), 1'b1, 32'h4000, 1'b1, 32'h77, 1'b0, 2'b10, 0,
                   32'h40 + 32'(g), 1'b0, 1'b0);
        runTxn("starve-fe", 1'b0, 32'h500, 1'b0, 32'h0, 1'b0, 2'b10, 0, 32'h99, 1'b1, 1'b0);
        runTxn("starve-resume", 1'b1, 32'h4000, 1'b1, 32'h77, 1'b0, 2'b10, 0, 32'h5A, 1'b0, 1'b1);

        $display("[TB] reset during BUS");
        fe_req = 1'b1; fe_addr = 32'h600;
        @(negedge clk);
        checkOutput("pre-reset bus_req", bus_req, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("async reset bus_req", bus_req, 0);
        fe_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = '0;
        checkOutput("late bus_ack acks", {bus_req, fe_ack, mem_ack}, 0);
        @(negedge clk);
        checkOutput("late bus_ack acks+1", {bus_req, fe_ack, mem_ack}, 0);

`ifdef MEM_ARB_TIMEOUT_EN
        $display("[TB] bus timeout");
        begin
            int high = 0;
            mem_req = 1'b1; mem_addr = 32'h7000; mem_write = 1'b0; mem_width = 2'b10;
            @(negedge clk);
            while (bus_req && high < 20) begin
                high++;
                @(negedge clk);
            end
            mem_req = 1'b0;
            checkOutput("timeout bus_req cycles", high, 8);
            checkOutput("timeout ack/err", {fe_ack, fe_err, mem_ack, mem_err}, 4'b0011);
            checkOutput("timeout mem_rdata", mem_rdata, 0);
            @(negedge clk);
            checkOutput("timeout single pulse", {mem_ack, mem_err}, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
